// File: rtl/md_pkg.sv
// Shared types and constants for the RV32M iterative multiply/divide unit.
package md_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN   = 32'h8000_0000;

    typedef enum logic [2:0] {
        MdMul    = 3'd0,
        MdMulh   = 3'd1,
        MdMulhsu = 3'd2,
        MdMulhu  = 3'd3,
        MdDiv    = 3'd4,
        MdDivu   = 3'd5,
        MdRem    = 3'd6,
        MdRemu   = 3'd7
    } md_op_t;

    typedef logic [1:0] md_state_t;

    localparam md_state_t StIdle = 2'd0;
    localparam md_state_t StCalc = 2'd1;
    localparam md_state_t StFix  = 2'd2;
    localparam md_state_t StDone = 2'd3;

endpackage

// File: rtl/md_unit_ctrl_if.sv
// Execute-stage handshake between the pipeline and the multiply/divide sequencer.
interface md_unit_ctrl_if;
    import md_pkg::*;

    logic            start_i;
    md_op_t          op_i;
    logic [XLEN-1:0] srcA_i;
    logic [XLEN-1:0] srcB_i;
    logic            flush_i;
    logic            stall_o;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport slave (
        input  start_i, op_i, srcA_i, srcB_i, flush_i,
        output stall_o, busy_o, done_o, result_o
    );

    modport master (
        output start_i, op_i, srcA_i, srcB_i, flush_i,
        input  stall_o, busy_o, done_o, result_o
    );

endinterface

// File: rtl/md_iter_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on {hi, lo} accumulator.
module md_iter_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic              is_div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opnd_i,
    output logic [2*XLEN-1:0] acc_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] rs;
    logic [XLEN:0] diff;

    always_comb begin
        sum  = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        rs   = {acc_i[2*XLEN-1:XLEN], acc_i[XLEN-1]};
        // Remainder stays below the divisor, so diff's top bit is purely the borrow.
        diff = rs - {1'b0, opnd_i};
        if (is_div_i) begin
            if (!diff[XLEN]) begin
                acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
            end else begin
                acc_o = {rs[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_o = {sum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/md_unit_ctrl.sv
// Iterative RV32M sequencer: 32 radix-2 steps on magnitudes, then one sign-fix cycle.
module md_unit_ctrl #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 5
) (
    input logic           clk,
    input logic           rst_n,
    md_unit_ctrl_if.slave bus_io
);
    import md_pkg::*;

    md_state_t         state_q, state_d;
    md_op_t            op_q;
    logic              neg_q;
    logic [XLEN-1:0]   opnd_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d, acc_step;
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept, is_div, is_rem, a_signed, b_signed, a_neg, b_neg, fast;
    logic [XLEN-1:0]   a_mag, b_mag, fast_res, fix_res;
    logic [2*XLEN-1:0] prod;

    always_comb begin
        accept   = (state_q == StIdle) & bus_io.start_i & ~bus_io.flush_i;
        is_div   = bus_io.op_i[2];
        is_rem   = bus_io.op_i[1];
        a_signed = bus_io.op_i inside {MdMulh, MdMulhsu, MdDiv, MdRem};
        b_signed = bus_io.op_i inside {MdMulh, MdDiv, MdRem};
        a_neg    = a_signed & bus_io.srcA_i[XLEN-1];
        b_neg    = b_signed & bus_io.srcB_i[XLEN-1];
        a_mag    = a_neg ? -bus_io.srcA_i : bus_io.srcA_i;
        b_mag    = b_neg ? -bus_io.srcB_i : bus_io.srcB_i;
        fast     = is_div & ((bus_io.srcB_i == '0) |
                   (b_signed & (bus_io.srcA_i == INT_MIN) & (bus_io.srcB_i == '1)));
        if (bus_io.srcB_i == '0) begin
            fast_res = is_rem ? bus_io.srcA_i : DIV0_QUOT;
        end else begin
            fast_res = is_rem ? '0 : INT_MIN;
        end
    end

    md_iter_step #(
        .XLEN (XLEN)
    ) u_step (
        .is_div_i (op_q[2]),
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .acc_o    (acc_step)
    );

    // neg_q already encodes which sign rule applies to the latched op.
    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        case (op_q)
            MdMul:                   fix_res = prod[XLEN-1:0];
            MdMulh, MdMulhsu, MdMulhu: fix_res = prod[2*XLEN-1:XLEN];
            MdDiv, MdDivu:           fix_res = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
            MdRem, MdRemu:           fix_res = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
            default:                 fix_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        result_d = result_q;
        if (bus_io.flush_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (fast) begin
                            result_d = fast_res;
                            state_d  = StDone;
                        end else begin
                            acc_d   = {{XLEN{1'b0}}, is_div ? a_mag : b_mag};
                            cnt_d   = '1;
                            state_d = StCalc;
                        end
                    end
                end
                StCalc: begin
                    acc_d = acc_step;
                    if (cnt_q == '0) begin
                        state_d = StFix;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                StFix: begin
                    result_d = fix_res;
                    state_d  = StDone;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            op_q     <= MdMul;
            neg_q    <= 1'b0;
            opnd_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            if (accept) begin
                op_q   <= bus_io.op_i;
                opnd_q <= is_div ? b_mag : a_mag;
                neg_q  <= (is_div & is_rem) ? a_neg : (a_neg ^ b_neg);
            end
        end
    end

    assign bus_io.busy_o   = (state_q == StCalc) | (state_q == StFix);
    assign bus_io.stall_o  = accept | bus_io.busy_o;
    assign bus_io.done_o   = (state_q == StDone);
    assign bus_io.result_o = result_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Scoreboard bench for md_unit_ctrl: results queued at issue, popped at done_o.
module tb_md_unit_ctrl;
    import md_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    md_unit_ctrl_if bus ();

    md_unit_ctrl #(
        .XLEN  (32),
        .CNT_W (5)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_res = 32'h0;

    function automatic logic [31:0] model(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        logic        ovf;
        ea  = (op == MdMulh || op == MdMulhsu) ? {{32{a[31]}}, a} : {32'h0, a};
        eb  = (op == MdMulh) ? {{32{b[31]}}, b} : {32'h0, b};
        p   = ea * eb;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            MdMul:                     return p[31:0];
            MdMulh, MdMulhsu, MdMulhu: return p[63:32];
            MdDiv:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
            MdDivu: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MdRem:  return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
            MdRemu: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    // Issue one op, hold start_i until it leaves execute, scramble operands after acceptance.
    task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_lat, input string name);
        int          cycles;
        int          stalls;
        bit          got;
        logic [31:0] e;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.srcA_i  = a;
        bus.srcB_i  = b;
        bus.flush_i = 1'b0;
        cycles = 0;
        stalls = 0;
        got    = 1'b0;
        while (!got && cycles < 80) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) begin
                got = 1'b1;
            end else begin
                if (bus.stall_o === 1'b1) stalls++;
                @(posedge clk); #1;
                cycles++;
                bus.srcA_i = $urandom;
                bus.srcB_i = $urandom;
                bus.op_i   = md_op_t'($urandom_range(0, 7));
            end
        end
        e = exp_q.pop_front();
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s timeout: done_o not seen after %0d cycles, required %0d", name, cycles, exp_lat);
        end else begin
            n_checks++;
            if (bus.result_o !== e) begin
                n_fail++;
                $display("FAIL %s result: got %h, required %h", name, bus.result_o, e);
            end
            n_checks++;
            if (cycles !== exp_lat) begin
                n_fail++;
                $display("FAIL %s latency: got %0d, required %0d", name, cycles, exp_lat);
            end
            n_checks++;
            if (stalls !== exp_lat || bus.stall_o !== 1'b0) begin
                n_fail++;
                $display("FAIL %s stall: %0d stall cycles (stall in done=%b), required %0d and 0",
                         name, stalls, bus.stall_o, exp_lat);
            end
        end
        // start_i still high across the DONE->IDLE edge: must not restart.
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.result_o !== e) begin
            n_fail++;
            $display("FAIL %s after-done: done=%b busy=%b result=%h, required 0 0 %h",
                     name, bus.done_o, bus.busy_o, bus.result_o, e);
        end
        last_res = e;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.stall_o !== 1'b0 || bus.result_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset: done=%b busy=%b stall=%b result=%h, required 0 0 0 0",
                     bus.done_o, bus.busy_o, bus.stall_o, bus.result_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_mul();
        run_op(MdMul,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul_7x-3");
        run_op(MdMulh,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh_min");
        run_op(MdMulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu_ones");
        run_op(MdMulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu_ones");
    endtask

    task automatic test_div();
        run_op(MdDiv,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_-7/2");
        run_op(MdRem,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_-7/2");
        run_op(MdDivu, 32'd100,       32'd7, 32'd14,        34, "divu_100/7");
        run_op(MdRemu, 32'd100,       32'd7, 32'd2,         34, "remu_100/7");
    endtask

    task automatic test_fast_path();
        run_op(MdDivu, 32'd5,         32'd0,         32'hFFFF_FFFF, 1, "divu_by0");
        run_op(MdRem,  32'd5,         32'd0,         32'd5,         1, "rem_by0");
        run_op(MdDiv,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        run_op(MdRem,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1, "rem_ovf");
    endtask

    task automatic test_flush();
        int dones;
        @(posedge clk); #1;
        bus.start_i = 1'b1;
        bus.op_i    = MdDiv;
        bus.srcA_i  = 32'd1000;
        bus.srcB_i  = 32'd7;
        repeat (11) @(posedge clk);
        #1 bus.flush_i = 1'b1;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        bus.start_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.stall_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.result_o !== last_res) begin
            n_fail++;
            $display("FAIL flush: stall=%b busy=%b done=%b result=%h, required 0 0 0 %h",
                     bus.stall_o, bus.busy_o, bus.done_o, bus.result_o, last_res);
        end
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL flush_no_done: got %0d done pulses, required 0", dones);
        end
        run_op(MdMul, 32'd3, 32'd4, 32'd12, 34, "mul_after_flush");
    endtask

    task automatic test_async_reset();
        int dones;
        @(posedge clk); #1;
        bus.start_i = 1'b1;
        bus.op_i    = MdMulhu;
        bus.srcA_i  = 32'h1234_5678;
        bus.srcB_i  = 32'h9ABC_DEF0;
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.result_o !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: done=%b busy=%b result=%h, required 0 0 0",
                     bus.done_o, bus.busy_o, bus.result_o);
        end
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) dones++;
        end
        n_checks++;
        if (dones !== 0) begin
            n_fail++;
            $display("FAIL async_reset_no_done: got %0d done pulses, required 0", dones);
        end
        last_res = 32'h0;
    endtask

    task automatic test_back_to_back();
        md_op_t      op;
        logic [31:0] a, b;
        int          lat;
        for (int i = 0; i < 10; i++) begin
            op = md_op_t'($urandom_range(0, 7));
            a  = (i == 3) ? 32'h8000_0000 : $urandom;
            b  = (i == 3) ? 32'hFFFF_FFFF : (i == 5) ? 32'h0 : $urandom_range(0, 3) == 0 ? 32'($urandom_range(1, 9)) : $urandom;
            lat = (op[2] && (b == 0 || ((op == MdDiv || op == MdRem) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 1 : 34;
            run_op(op, a, b, model(op, a, b), lat, "random");
        end
    endtask

    initial begin
        bus.start_i = 1'b0;
        bus.op_i    = MdMul;
        bus.srcA_i  = 32'h0;
        bus.srcB_i  = 32'h0;
        bus.flush_i = 1'b0;
        test_reset();
        test_mul();
        test_div();
        test_fast_path();
        test_flush();
        test_async_reset();
        run_op(MdRemu, 32'd9, 32'd4, 32'd1, 34, "after_reset");
        test_back_to_back();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/md_unit_ctrl.md
Name: md_unit_ctrl

Overview:
- Iterative RV32M multiply/divide sequencer attached to the execute stage beside the ALU.
- Accepts one M-extension operation when the execute stage presents it, and stalls the front of the pipeline while it iterates.
- Presents the 32-bit result for exactly one cycle, in the cycle the instruction leaves execute.
- One operation in flight at a time; no queueing.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 5, iteration counter width, equal to log2(XLEN).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  execute-stage instruction is an M-op; held high until it leaves execute.
- op_i  in  3  md_op_t: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- srcA_i  in  32  rs1 operand (forwarded value).
- srcB_i  in  32  rs2 operand (forwarded value).
- flush_i  in  1  execute-stage flush (taken branch/jump redirect).
- stall_o  out  1  hold fetch/decode/execute registers.
- busy_o  out  1  state is CALC or FIX.
- done_o  out  1  result valid this cycle.
- result_o  out  32  operation result, valid when done_o=1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; done_o=0, busy_o=0, result_o=0, counter=0. Reset mid-operation discards the operation with no done_o.
- States: IDLE, CALC, FIX, DONE.
- IDLE, start_i=1, flush_i=0: latch op, operands and sign flags.
  - Fast path (div/rem with srcB=0; or DIV/REM with srcA=0x80000000 and srcB=0xFFFFFFFF): go to DONE with result loaded directly.
  - Otherwise go to CALC with counter=31.
- CALC: one radix-2 step per cycle on operand magnitudes.
  - Multiply: shift-add over a 64-bit accumulator.
  - Divide: restoring, 32-bit remainder and quotient.
  - Leave for FIX when counter==0; counter decrements by 1 each step.
- FIX: apply two's-complement sign correction, select low/high half or quotient/remainder into result_o, go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE unconditionally. start_i is ignored in DONE (same instruction, still in execute).
- Latency, normal path: start sampled at edge E0; done_o high in the cycle after edge E0+33 (32 CALC + 1 FIX).
- Latency, fast path: done_o high in the cycle after E0.
- stall_o = (state==IDLE & start_i & ~flush_i) | state==CALC | state==FIX. Combinational, so the issuing cycle already stalls. stall_o=0 in DONE.
- busy_o = state in {CALC, FIX}.
- result_o holds its last value outside DONE; consumers must qualify it with done_o.
- Sign rules:
  - MULH: both operands signed.
  - MULHSU: A signed, B unsigned.
  - MULHU/DIVU/REMU: both unsigned.
  - MUL: low 32 bits, identical for all signedness.
  - DIV: quotient negated if signs differ.
  - REM: remainder takes the dividend's sign.
- Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return srcA.
- Signed overflow (DIV/REM only, 0x80000000 / -1): DIV returns 0x80000000; REM returns 0.
- flush_i=1 in any state: next state IDLE, no done_o, result_o unchanged. flush_i has priority over start_i and over the CALC→FIX transition.
- op_i/srcA_i/srcB_i changes after acceptance have no effect; operands are captured at start.

Decomposition:
- Package md_pkg: md_op_t enum (3 bits), md_state_t enum (IDLE/CALC/FIX/DONE), constants XLEN=32, DIV0_QUOT=32'hFFFF_FFFF, INT_MIN=32'h8000_0000.
- One natural sub-module, md_iter_step: combinational single multiply/divide step (accumulator/remainder in → next value out). The FSM, counter, operand latches and sign fix stay in md_unit_ctrl.

Test Plan:
- MUL srcA=7, srcB=-3 (0xFFFFFFFD) → stall_o high from issue cycle for 34 cycles; done_o pulses once 34 cycles after E0; result_o=0xFFFFFFEB.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/-1 → 0x80000000; all fast path, done_o one cycle after start, stall_o high only in the issue cycle.
- Start DIV, assert flush_i at CALC cycle 10 → IDLE next edge, stall_o=0, no done_o. A new MUL 3×4 immediately after → 12 after 34 cycles.
- Assert rst_n=0 asynchronously mid-CALC → outputs 0 immediately, no done_o. start_i held high through DONE → exactly one done_o, no restart.
